// File: rtl/wb_user_bridge_pkg.sv
// Shared definitions for the Wishbone-to-user-register bridge.
//   state_t          : bridge FSM encoding
//   ERR_DATA_DEFAULT : read data returned when an access times out
//   sat_inc8         : saturating 8-bit increment for event counters
package wb_user_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_user_bridge_if.sv
// Wishbone classic bus as seen by a user-space slave.
//   wbs_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i : master -> slave
//   wbs_ack_o/dat_o                        : slave -> master
// Modports: master (drives the cycle), slave (the bridge).
interface wb_user_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_user_timer.sv
// Access timer shared by the REQ, WAIT and DRAIN phases.
//   clk, rst_n : clock, async active-low reset
//   load       : restart the count at 0 (wins over inc)
//   inc        : advance the count by one
//   hit        : this cycle is the TIMEOUT-th cycle since the last load,
//                so the owning state gives up on this edge
module wb_user_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic hit
);
  // One spare bit so the post-timeout increment in ACK cannot alias a hit.
  localparam int TW = $clog2(TIMEOUT + 1) + 1;

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= '0;
    else if (inc)  cnt <= cnt + 1'b1;
  end

  // The count is 0 in the first cycle after a load, so TIMEOUT-1 marks
  // the last cycle of a TIMEOUT-cycle window.
  assign hit = (cnt == TW'(TIMEOUT - 1));
endmodule

// File: rtl/wb_user_bridge.sv
// Wishbone classic slave -> single-outstanding valid/ready backend bridge.
//   wb_clk_i, wb_rst_n : clock, async active-low reset
//   wb                 : Wishbone slave port (cyc already user-space qualified)
//   req_*              : request toward user register logic (valid/ready)
//   rsp_valid/rdata    : one-cycle response pulse from the backend
//   busy               : FSM is not IDLE
//   timeout_cnt        : saturating count of timed-out accesses
// Every access is bounded by TIMEOUT cycles; a timed-out read returns
// ERR_DATA. If the backend accepted the request before timing out, its late
// response is absorbed in DRAIN so it cannot be mistaken for the next access.
module wb_user_bridge
  import wb_user_bridge_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  wb_user_bridge_if.slave   wb,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [3:0]        req_sel,
  output logic [ADDR_W-1:0] req_addr,
  output logic [31:0]       req_wdata,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_rdata,
  output logic              busy,
  output logic [7:0]        timeout_cnt
);

  state_t state;
  logic   drop;      // backend owes us a response we will discard
  logic   tmr_load;
  logic   tmr_inc;
  logic   tmr_hit;
  logic   stb;

  assign stb  = wb.wbs_cyc_i & wb.wbs_stb_i;
  assign busy = (state != ST_IDLE);

  // Byte-offset and above-window address bits are not forwarded.
  logic unused_adr;
  assign unused_adr = ^{wb.wbs_adr_i[31:ADDR_W+2], wb.wbs_adr_i[1:0]};

  // Timer restarts on request issue and on every entry into DRAIN; these
  // conditions mirror the matching transitions in the FSM below.
  always_comb begin
    tmr_load = 1'b0;
    case (state)
      ST_IDLE: tmr_load = stb;
      ST_WAIT: tmr_load = !rsp_valid && !wb.wbs_cyc_i;
      ST_ACK:  tmr_load = drop;
      default: tmr_load = 1'b0;
    endcase
  end

  assign tmr_inc = (state != ST_IDLE);

  wb_user_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .load  (tmr_load),
    .inc   (tmr_inc),
    .hit   (tmr_hit)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state         <= ST_IDLE;
      drop          <= 1'b0;
      wb.wbs_ack_o  <= 1'b0;
      wb.wbs_dat_o  <= '0;
      req_valid     <= 1'b0;
      req_we        <= 1'b0;
      req_sel       <= '0;
      req_addr      <= '0;
      req_wdata     <= '0;
      timeout_cnt   <= '0;
    end else begin
      wb.wbs_ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (stb) begin
            state     <= ST_REQ;
            req_valid <= 1'b1;
            req_we    <= wb.wbs_we_i;
            req_sel   <= wb.wbs_sel_i;
            req_addr  <= wb.wbs_adr_i[ADDR_W+1:2];
            req_wdata <= wb.wbs_dat_i;
          end
        end
        // abort > handshake > timeout
        ST_REQ: begin
          if (!wb.wbs_cyc_i) begin
            state     <= ST_IDLE;
            req_valid <= 1'b0;
          end else if (req_ready) begin
            state     <= ST_WAIT;
            req_valid <= 1'b0;
          end else if (tmr_hit) begin
            // Request never accepted: nothing to drain afterwards.
            state        <= ST_ACK;
            req_valid    <= 1'b0;
            timeout_cnt  <= sat_inc8(timeout_cnt);
            wb.wbs_ack_o <= 1'b1;
            wb.wbs_dat_o <= ERR_DATA;
          end
        end
        // response > abort > timeout
        ST_WAIT: begin
          if (rsp_valid) begin
            state        <= ST_ACK;
            wb.wbs_ack_o <= 1'b1;
            wb.wbs_dat_o <= rsp_rdata;
          end else if (!wb.wbs_cyc_i) begin
            state <= ST_DRAIN;
          end else if (tmr_hit) begin
            state        <= ST_ACK;
            drop         <= 1'b1;
            timeout_cnt  <= sat_inc8(timeout_cnt);
            wb.wbs_ack_o <= 1'b1;
            wb.wbs_dat_o <= ERR_DATA;
          end
        end
        ST_ACK: begin
          wb.wbs_dat_o <= '0;
          state        <= drop ? ST_DRAIN : ST_IDLE;
        end
        ST_DRAIN: begin
          if (rsp_valid || tmr_hit) begin
            state <= ST_IDLE;
            drop  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          drop      <= 1'b0;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_user_bridge.sv
// Self-checking bench for wb_user_bridge (TIMEOUT=8). Stimulus pushes the
// expected ack data into a scoreboard queue; a negedge monitor pops and
// compares on every ack, and flags acks nobody asked for.
module tb_wb_user_bridge;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid, req_ready, req_we;
  logic [3:0]        req_sel;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              busy;
  logic [7:0]        timeout_cnt;

  wb_user_bridge_if wb();

  wb_user_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n    (rst_n),
    .wb          (wb),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_sel     (req_sel),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .busy        (busy),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor
  logic ack_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n && wb.wbs_ack_o) begin
      if (ack_prev) chk("ack_width", 32'd2, 32'd1);
      if (exp_q.size() == 0) chk("spurious_ack", 32'd1, 32'd0);
      else chk("ack_data", wb.wbs_dat_o, exp_q.pop_front());
    end
    ack_prev = rst_n && wb.wbs_ack_o;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input logic we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] wd);
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
    wb.wbs_adr_i = adr;  wb.wbs_sel_i = sel;  wb.wbs_dat_i = wd;
  endtask

  task automatic idle_bus();
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
  endtask

  // Wait (bounded) until ack is high at the sampling point.
  task automatic wait_ack(input string name);
    int n = 0;
    while (!wb.wbs_ack_o && n < 40) begin tick(); n++; end
    if (!wb.wbs_ack_o) chk(name, 32'd0, 32'd1);
  endtask

  // Fastest read: ready with valid, response on the next cycle.
  task automatic quick_read(input logic [31:0] adr, input logic [31:0] rd);
    start(1'b0, adr, 4'hF, 32'h0);
    req_ready = 1'b1;
    exp_q.push_back(rd);
    tick();                                  // REQ
    tick(); req_ready = 1'b0;                // WAIT
    rsp_valid = 1'b1; rsp_rdata = rd;
    tick(); rsp_valid = 1'b0;                // ACK
    chk("quick_ack", {31'd0, wb.wbs_ack_o}, 32'd1);
    idle_bus();
    tick();
  endtask

  initial begin
    int n;
    idle_bus();
    wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
    #12;
    // ---- reset state
    chk("rst_ack",   {31'd0, wb.wbs_ack_o}, 0);
    chk("rst_dat",   wb.wbs_dat_o, 0);
    chk("rst_valid", {31'd0, req_valid}, 0);
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst_tocnt", {24'd0, timeout_cnt}, 0);
    chk("rst_fields", {req_we, req_sel, req_addr, req_wdata[14:0]}, 0);
    tick(); rst_n = 1'b1; tick();

    // ---- 1: minimum-latency read, ack exactly 3 cycles after stb
    start(1'b0, 32'h0000_0020, 4'hF, 32'h0);
    req_ready = 1'b1;
    exp_q.push_back(32'h1234_5678);
    tick();
    chk("rd_valid", {31'd0, req_valid}, 1);
    chk("rd_addr",  {20'd0, req_addr}, 32'd8);
    tick(); req_ready = 1'b0;
    chk("rd_ack_early", {31'd0, wb.wbs_ack_o}, 0);
    rsp_valid = 1'b1; rsp_rdata = 32'h1234_5678;
    tick(); rsp_valid = 1'b0;
    chk("rd_ack_lat", {31'd0, wb.wbs_ack_o}, 1);
    idle_bus();
    tick();
    chk("rd_ack_off", {31'd0, wb.wbs_ack_o}, 0);
    chk("rd_dat_off", wb.wbs_dat_o, 0);
    chk("rd_busy",    {31'd0, busy}, 0);
    chk("rd_tocnt",   {24'd0, timeout_cnt}, 0);

    // ---- 2: write, fields stable while ready is low
    start(1'b1, 32'h3000_0010, 4'b0011, 32'hA5A5_0F0F);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("wr_valid", {31'd0, req_valid}, 1);
      chk("wr_addr",  {20'd0, req_addr}, 32'd4);
      chk("wr_we",    {31'd0, req_we}, 1);
      chk("wr_sel",   {28'd0, req_sel}, 32'h3);
      chk("wr_wdata", req_wdata, 32'hA5A5_0F0F);
      if (i == 2) req_ready = 1'b1;
      tick();
    end
    req_ready = 1'b0;
    chk("wr_valid_drop", {31'd0, req_valid}, 0);
    exp_q.push_back(32'h0BAD_F00D);
    rsp_valid = 1'b1; rsp_rdata = 32'h0BAD_F00D;
    tick(); rsp_valid = 1'b0;
    idle_bus();
    tick();

    // ---- 3: request never accepted -> timeout after 8 cycles of req_valid
    start(1'b0, 32'h0000_0040, 4'hF, 32'h0);
    exp_q.push_back(ERR);
    tick();
    n = 0;
    while (req_valid && n < 20) begin n++; tick(); end
    chk("to_req_cycles", n, 8);
    chk("to_req_ack", {31'd0, wb.wbs_ack_o}, 1);
    idle_bus();
    tick();
    chk("to_req_cnt",  {24'd0, timeout_cnt}, 1);
    chk("to_req_busy", {31'd0, busy}, 0);

    // ---- 4: accepted but no response -> ERR ack, DRAIN absorbs late rsp
    start(1'b0, 32'h0000_0044, 4'hF, 32'h0);
    req_ready = 1'b1;
    exp_q.push_back(ERR);
    tick();
    tick(); req_ready = 1'b0;
    wait_ack("to_wait_ack");
    idle_bus();
    tick();
    chk("drain_busy", {31'd0, busy}, 1);
    chk("drain_cnt",  {24'd0, timeout_cnt}, 2);
    start(1'b0, 32'h0000_0048, 4'hF, 32'h0);   // stalled during DRAIN
    tick(); tick();
    rsp_valid = 1'b1; rsp_rdata = 32'hFFFF_0000;
    tick(); rsp_valid = 1'b0;
    chk("drain_exit", {31'd0, busy}, 0);
    exp_q.push_back(32'h5555_AAAA);
    req_ready = 1'b1;
    tick();
    tick(); req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_rdata = 32'h5555_AAAA;
    tick(); rsp_valid = 1'b0;
    idle_bus();
    tick();

    // ---- 5a: abort in REQ
    start(1'b0, 32'h0000_0050, 4'hF, 32'h0);
    tick();
    idle_bus();
    tick();
    chk("abort_req_valid", {31'd0, req_valid}, 0);
    chk("abort_req_busy",  {31'd0, busy}, 0);

    // ---- 5b: abort in WAIT -> DRAIN until response, then normal access
    start(1'b0, 32'h0000_0054, 4'hF, 32'h0);
    req_ready = 1'b1;
    tick();
    tick(); req_ready = 1'b0;
    idle_bus();
    tick();
    chk("abort_wait_busy", {31'd0, busy}, 1);
    tick();
    rsp_valid = 1'b1; rsp_rdata = 32'h7777_7777;
    tick(); rsp_valid = 1'b0;
    chk("abort_wait_idle", {31'd0, busy}, 0);
    quick_read(32'h0000_0058, 32'hCAFE_0001);

    // ---- 6: response on the timeout cycle wins
    start(1'b0, 32'h0000_005C, 4'hF, 32'h0);
    req_ready = 1'b1;
    exp_q.push_back(32'h0123_4567);
    tick();
    tick(); req_ready = 1'b0;
    repeat (6) tick();
    rsp_valid = 1'b1; rsp_rdata = 32'h0123_4567;
    tick(); rsp_valid = 1'b0;
    chk("coinc_ack", {31'd0, wb.wbs_ack_o}, 1);
    idle_bus();
    tick();
    chk("coinc_cnt", {24'd0, timeout_cnt}, 2);

    // ---- 7: 300 forced timeouts saturate the counter
    for (int k = 0; k < 300; k++) begin
      start(1'b0, 32'h0000_0060, 4'hF, 32'h0);
      exp_q.push_back(ERR);
      tick();
      wait_ack("sat_ack");
      idle_bus();
      tick();
    end
    chk("sat_cnt", {24'd0, timeout_cnt}, 32'hFF);

    // ---- 8: reset mid-transaction
    start(1'b0, 32'h0000_0064, 4'hF, 32'h0);
    tick();
    #2 rst_n = 1'b0; #1;
    chk("midrst_valid", {31'd0, req_valid}, 0);
    chk("midrst_busy",  {31'd0, busy}, 0);
    chk("midrst_cnt",   {24'd0, timeout_cnt}, 0);
    idle_bus();
    tick(); rst_n = 1'b1; tick();
    quick_read(32'h0000_0068, 32'hBEEF_0002);

    repeat (2) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wb_user_bridge.md
Name: wb_user_bridge

Overview:
- Wishbone classic slave that sits directly downstream of the user_project_wrapper address split.
- Consumes the user-space cycle qualifier (the wrapper's user-side cyc) plus the shared Wishbone bus.
- Converts each Wishbone access into a single-outstanding valid/ready request toward user register logic, and returns that logic's response as a one-cycle ack with read data.
- Bounds every access with a timeout, so an unresponsive user block cannot hang the management core.

Parameters:
- ADDR_W, 12: word-address width forwarded to the backend; the backend receives wbs_adr_i[ADDR_W+1:2].
- TIMEOUT, 255: cycles from request issue to forced completion; must be at least 2.
- ERR_DATA, 32'hDEAD_BEEF: value returned on wbs_dat_o for a timed-out read.

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_n  in  1  asynchronous, active-low reset.
- wbs_cyc_i  in  1  user-space qualified cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- req_valid  out  1  backend request valid.
- req_ready  in  1  backend accepts the request.
- req_we  out  1  request is a write.
- req_sel  out  4  byte selects.
- req_addr  out  ADDR_W  word address.
- req_wdata  out  32  write data.
- rsp_valid  in  1  backend response, single-cycle pulse.
- rsp_rdata  in  32  response read data.
- busy  out  1  high whenever the FSM is not in IDLE.
- timeout_cnt  out  8  saturating count of timed-out accesses.

Behaviour:
- Reset (async assert, sync release): state=IDLE; wbs_ack_o=0, wbs_dat_o=0, req_valid=0, req_we/req_sel/req_addr/req_wdata=0, busy=0, timeout_cnt=0, drop flag=0, timer=0.
- IDLE
  - On wbs_cyc_i&wbs_stb_i, register we/sel/addr/wdata and go to REQ.
  - req_valid rises in the next cycle. Timer loads 0.
- REQ
  - req_valid=1, and request fields are held stable.
  - req_valid&req_ready: go to WAIT.
  - wbs_cyc_i=0 (abort): drop req_valid and go to IDLE. No ack is issued.
  - Timer reaches TIMEOUT: drop req_valid, timeout_cnt+1, go to ACK with dat=ERR_DATA.
- WAIT
  - rsp_valid: capture rsp_rdata (writes capture it too and it is ignored), go to ACK.
  - Backend must not assert rsp_valid in the same cycle as the req handshake; rsp_valid is ignored in IDLE, REQ and ACK.
  - wbs_cyc_i=0: go to DRAIN.
  - Timer reaches TIMEOUT: timeout_cnt+1, set drop flag, go to ACK with ERR_DATA.
- ACK
  - wbs_ack_o=1 for exactly one cycle, with wbs_dat_o valid in that same cycle.
  - Next state: DRAIN if the drop flag is set, else IDLE.
  - wbs_dat_o returns to 0 when ack deasserts.
  - A new stb is never accepted in the ACK cycle.
- DRAIN
  - Waits for the late response, or for a further TIMEOUT cycles (timer restarts on entry), then clears the drop flag and goes to IDLE.
  - The late rsp_valid is discarded.
  - wbs_cyc_i/stb are not sampled in DRAIN; the master is stalled, not acked.
- Priority within one cycle
  - REQ: abort > handshake > timeout.
  - WAIT: rsp_valid > abort > timeout. A response arriving on the timeout cycle completes normally; it is not counted as a timeout.
- Counters
  - The timer increments every non-IDLE cycle.
  - timeout_cnt saturates at 8'hFF; it does not wrap.
- Latency
  - Minimum stb-to-ack is 3 cycles: stb seen at N, req_valid at N+1 with ready at N+1, rsp at N+2, ack at N+3.
  - Back-to-back accesses: the next stb is accepted the cycle after ack.
- Reset asserted mid-transaction: immediate return to reset values; any in-flight backend response is the backend's concern.

Decomposition:
- Shared package holds the state encoding typedef (IDLE, REQ, WAIT, ACK, DRAIN) and the default ERR_DATA constant.
- One natural sub-module, wb_user_timer: resettable up-counter with load and a TIMEOUT-compare output, reused for REQ/WAIT/DRAIN.

Test Plan:
- Read, backend ready immediately, rsp one cycle later with rdata=32'h1234_5678 -> ack exactly 3 cycles after stb, dat=32'h1234_5678, timeout_cnt=0.
- Write adr=32'h3000_0010, sel=4'b0011, wdata=32'hA5A5_0F0F -> req_addr=4, req_we=1, fields stable until ready; single ack pulse.
- req_ready held low, TIMEOUT=8 -> req_valid drops after 8 cycles, ack with dat=32'hDEAD_BEEF, timeout_cnt=1.
- Handshake done, no rsp, TIMEOUT=8 -> ERR_DATA ack; a late rsp 3 cycles later is discarded; a next stb during DRAIN is not acked until DRAIN exits.
- cyc dropped while in WAIT -> no ack, DRAIN entered; after the response arrives, busy=0; the next access completes normally.
- rsp_valid coincident with the timer reaching TIMEOUT -> normal data returned, timeout_cnt unchanged. Separately, 300 forced timeouts -> timeout_cnt=8'hFF.
